// File: rtl/maxil_pkg.sv
// rtl/maxil_pkg.sv - shared constants for the AXI4-Lite master read engine
// Holds the FSM state encoding and the AXI response codes.
package maxil_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
// Ports: clk, rst (sync, active-high), inc (count enable), count (current value).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Holds at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/maxil_read_top.sv
// rtl/maxil_read_top.sv - AXI4-Lite master read engine, one outstanding transaction
// Ports:
//   maxil_read_top_clk/rst            clock, synchronous active-high reset
//   cmd_valid/ready/addr/prot         requester command (single-word read)
//   maxil_read_ar*                    AXI AR channel (registered outputs)
//   maxil_read_r*                     AXI R channel (rready registered)
//   rsp_valid/ready/data/resp         captured response back to the requester
//   rd_count/err_count                saturating debug counters
module maxil_read_top
    import maxil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              maxil_read_top_clk,
    input  logic              maxil_read_top_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_prot,
    output logic              maxil_read_arvalid,
    input  logic              maxil_read_arready,
    output logic [ADDR_W-1:0] maxil_read_araddr,
    output logic [2:0]        maxil_read_arprot,
    input  logic              maxil_read_rvalid,
    output logic              maxil_read_rready,
    input  logic [DATA_W-1:0] maxil_read_rdata,
    input  logic [1:0]        maxil_read_rresp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  err_count
);

    logic [1:0]        state_q,     state_d;
    logic              arvalid_q,   arvalid_d;
    logic [ADDR_W-1:0] araddr_q,    araddr_d;
    logic [2:0]        arprot_q,    arprot_d;
    logic              rready_q,    rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic [1:0]        rsp_resp_q,  rsp_resp_d;

    logic rd_inc;
    logic err_inc;

    // R handshake: rready is high exactly while in DATA.
    assign rd_inc  = (state_q == DATA) && maxil_read_rvalid;
    assign err_inc = rd_inc && ((maxil_read_rresp == SLVERR) || (maxil_read_rresp == DECERR));

    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arprot_d    = arprot_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Low two bits are dropped to force word alignment.
                    araddr_d  = cmd_addr & ~ADDR_W'(3);
                    arprot_d  = cmd_prot;
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (maxil_read_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (maxil_read_rvalid) begin
                    rsp_data_d  = maxil_read_rdata;
                    rsp_resp_d  = maxil_read_rresp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge maxil_read_top_clk) begin
        if (maxil_read_top_rst) begin
            state_q     <= IDLE;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arprot_q    <= '0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arprot_q    <= arprot_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_rd_count (
        .clk   (maxil_read_top_clk),
        .rst   (maxil_read_top_rst),
        .inc   (rd_inc),
        .count (rd_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_count (
        .clk   (maxil_read_top_clk),
        .rst   (maxil_read_top_rst),
        .inc   (err_inc),
        .count (err_count)
    );

    assign cmd_ready          = (state_q == IDLE);
    assign maxil_read_arvalid = arvalid_q;
    assign maxil_read_araddr  = araddr_q;
    assign maxil_read_arprot  = arprot_q;
    assign maxil_read_rready  = rready_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_data           = rsp_data_q;
    assign rsp_resp           = rsp_resp_q;

endmodule
